// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the pipeline-side signals seen by the hazard controller.
//   master : pipeline / test side. Drives the register indices, the load and
//            redirect flags, the write enables and imemReady. Receives the
//            stall, flush and forward controls and the status outputs.
//   slave  : hazard controller side, with the directions reversed.
// Signals:
//   rs1D, rs2D               sources of the instruction in the fetch/decode bank
//   rs1E, rs2E, rdE          execute-stage sources and destination
//   memReadE, pcSrcE         execute-stage load flag and taken redirect
//   rdM, rdW                 memory/writeback destinations
//   regWriteM, regWriteW     memory/writeback write enables
//   imemReady                instruction memory returned data this cycle
//   stallF, weFD             hold PC / fetch-decode bank write enable
//   flushD, flushE           synchronous clears of the FD and DE banks
//   forwardAE, forwardBE     operand selects: 00 regfile, 10 from M, 01 from W
//   imemTimeout, stallCount  sticky memory timeout flag, total stall cycles
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic        memReadE;
    logic        pcSrcE;
    logic [4:0]  rdM;
    logic [4:0]  rdW;
    logic        regWriteM;
    logic        regWriteW;
    logic        imemReady;
    logic        stallF;
    logic        weFD;
    logic        flushD;
    logic        flushE;
    logic [1:0]  forwardAE;
    logic [1:0]  forwardBE;
    logic        imemTimeout;
    logic [31:0] stallCount;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, memReadE, pcSrcE,
        output rdM, rdW, regWriteM, regWriteW, imemReady,
        input  stallF, weFD, flushD, flushE, forwardAE, forwardBE,
        input  imemTimeout, stallCount
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, memReadE, pcSrcE,
        input  rdM, rdW, regWriteM, regWriteW, imemReady,
        output stallF, weFD, flushD, flushE, forwardAE, forwardBE,
        output imemTimeout, stallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard unit for a five-stage pipeline with a variable-latency instruction
// memory. It produces the PC stall, the fetch/decode write enable, the FD and
// DE bank flushes and the execute-stage forwarding selects. A three-state FSM
// tracks outstanding instruction fetches and redirects that arrive while a
// fetch is still outstanding.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears all state and forces the idle
//          output pattern while low
//   hz     hazard_ctrl_if.slave bundle (see hazard_ctrl_if for signal list)
// ---------------------------------------------------------------------------
module hazard_ctrl (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN           = 2'd0,
        WAIT_IMEM     = 2'd1,
        REDIRECT_PEND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic        mem_wait;
    logic        load_use;
    logic        stall_f;
    logic        we_fd;
    logic        flush_d;
    logic        flush_e;

    assign mem_wait = ~hz.imemReady;

    // A load in execute whose destination feeds the decode instruction.
    // x0 is never a real dependency.
    assign load_use = hz.memReadE && (hz.rdE != 5'd0) &&
                      ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    // ------------------------------------------------------------------
    // Forwarding: one identical selector per execute operand. M is the
    // younger producer, so it wins over W.
    // ------------------------------------------------------------------
    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd_sel;

    assign rs_e[0] = hz.rs1E;
    assign rs_e[1] = hz.rs2E;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic hit_m;
        logic hit_w;
        assign hit_m = hz.regWriteM && (hz.rdM != 5'd0) && (hz.rdM == rs_e[gi]);
        assign hit_w = hz.regWriteW && (hz.rdW != 5'd0) && (hz.rdW == rs_e[gi]);
        assign fwd_sel[gi] = !reset ? 2'b00 :
                             hit_m  ? 2'b10 :
                             hit_w  ? 2'b01 : 2'b00;
    end

    assign hz.forwardAE = fwd_sel[0];
    assign hz.forwardBE = fwd_sel[1];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = hz.pcSrcE ? REDIRECT_PEND : WAIT_IMEM;
                end
            end
            WAIT_IMEM: begin
                // A redirect arriving together with the data is handled as
                // an ordinary redirect flush this cycle, so go straight home.
                if (!mem_wait) begin
                    state_d = RUN;
                end else if (hz.pcSrcE) begin
                    state_d = REDIRECT_PEND;
                end
            end
            REDIRECT_PEND: begin
                if (!mem_wait) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline controls. Priority: redirect, memory wait, pending-redirect
    // discard, load-use. While reset is low the idle pattern is forced.
    // ------------------------------------------------------------------
    always_comb begin
        stall_f = 1'b0;
        we_fd   = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (reset) begin
            if (hz.pcSrcE) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                // The fetch is still outstanding: the PC must hold even
                // though the younger instructions are being squashed.
                if (mem_wait) begin
                    stall_f = 1'b1;
                    we_fd   = 1'b0;
                end
            end else if (mem_wait) begin
                stall_f = 1'b1;
                we_fd   = 1'b0;
                flush_e = 1'b1;
            end else if (state_q == REDIRECT_PEND) begin
                // The data that finally arrived belongs to the wrong path.
                flush_d = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                we_fd   = 1'b0;
                flush_e = 1'b1;
            end
        end
    end

    assign hz.stallF = stall_f;
    assign hz.weFD   = we_fd;
    assign hz.flushD = flush_d;
    assign hz.flushE = flush_e;

    // ------------------------------------------------------------------
    // Wait counter and sticky timeout. Cycles spent in RUN do not count,
    // so the first missing cycle only moves the FSM into a wait state.
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = 8'd0;
        if ((state_q != RUN) && mem_wait) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end
        timeout_d     = timeout_q | (wait_cnt_d == 8'hFF);
        stall_count_d = stall_count_q + 32'(stall_f);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            timeout_q     <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.imemTimeout = timeout_q;
    assign hz.stallCount  = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Drives hazard_ctrl one cycle at a time. Each cycle the expected controls,
// timeout flag and stall count are computed from a behavioural model of the
// hazard rules and pushed to a scoreboard queue; shortly after the inputs
// settle the entry is popped and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    logic clk;
    logic reset;

    hazard_ctrl_if hz_if ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ctl;   // {stallF, weFD, flushD, flushE, forwardAE, forwardBE}
        logic        tmo;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int txn   = 0;

    // model state: 0 RUN, 1 WAIT_IMEM, 2 REDIRECT_PEND
    int          m_state = 0;
    int          m_cnt   = 0;
    logic        m_tmo   = 1'b0;
    logic [31:0] m_stall = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (hz_if.regWriteM && hz_if.rdM != 5'd0 && hz_if.rdM == rs) return 2'b10;
        if (hz_if.regWriteW && hz_if.rdW != 5'd0 && hz_if.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [7:0] exp_ctl();
        logic s, w, fd, fe, lu, rdy;
        s = 1'b0; w = 1'b1; fd = 1'b0; fe = 1'b0;
        if (!reset) return {4'b0100, 4'b0000};
        rdy = hz_if.imemReady;
        lu  = hz_if.memReadE && hz_if.rdE != 5'd0 &&
              (hz_if.rdE == hz_if.rs1D || hz_if.rdE == hz_if.rs2D);
        if (hz_if.pcSrcE) begin
            fd = 1'b1; fe = 1'b1; s = !rdy; w = rdy;
        end else if (!rdy) begin
            s = 1'b1; w = 1'b0; fe = 1'b1;
        end else if (m_state == 2) begin
            fd = 1'b1;
        end else if (lu) begin
            s = 1'b1; w = 1'b0; fe = 1'b1;
        end
        return {s, w, fd, fe, exp_fwd(hz_if.rs1E), exp_fwd(hz_if.rs2E)};
    endfunction

    task automatic model_clock(input logic stall);
        logic rdy;
        rdy = hz_if.imemReady;
        m_stall = m_stall + 32'(stall);
        if (m_state != 0 && !rdy) begin
            if (m_cnt < 255) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        if (m_cnt == 255) m_tmo = 1'b1;
        if (rdy) m_state = 0;
        else if (hz_if.pcSrcE) m_state = 2;
        else if (m_state == 0) m_state = 1;
    endtask

    task automatic cycle(input string tag, input logic rst, input logic rdy, input logic pc,
                         input logic mre, input logic [4:0] rde,
                         input logic [4:0] r1d, input logic [4:0] r2d);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset           = rst;
        hz_if.imemReady = rdy;
        hz_if.pcSrcE    = pc;
        hz_if.memReadE  = mre;
        hz_if.rdE       = rde;
        hz_if.rs1D      = r1d;
        hz_if.rs2D      = r2d;
        if (!rst) begin
            m_state = 0; m_cnt = 0; m_tmo = 1'b0; m_stall = 32'd0;
        end
        e.ctl = exp_ctl();
        e.tmo = m_tmo;
        e.cnt = m_stall;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        check({tag, "/ctl"}, 64'({hz_if.stallF, hz_if.weFD, hz_if.flushD, hz_if.flushE,
                                  hz_if.forwardAE, hz_if.forwardBE}), 64'(got.ctl));
        check({tag, "/tmo"}, 64'(hz_if.imemTimeout), 64'(got.tmo));
        check({tag, "/cnt"}, 64'(hz_if.stallCount), 64'(got.cnt));
        txn++;
        $display("txn %0d %s rst=%b rdy=%b pc=%b ctl=%b tmo=%b cnt=%0h", txn, tag, rst, rdy, pc,
                 {hz_if.stallF, hz_if.weFD, hz_if.flushD, hz_if.flushE, hz_if.forwardAE,
                  hz_if.forwardBE}, hz_if.imemTimeout, hz_if.stallCount);
        @(posedge clk);
        if (rst) model_clock(e.ctl[7]);
    endtask

    task automatic set_fwd(input logic wm, input logic ww, input logic [4:0] rm,
                           input logic [4:0] rw, input logic [4:0] r1, input logic [4:0] r2);
        hz_if.regWriteM = wm;
        hz_if.regWriteW = ww;
        hz_if.rdM       = rm;
        hz_if.rdW       = rw;
        hz_if.rs1E      = r1;
        hz_if.rs2E      = r2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        hz_if.imemReady = 1'b1; hz_if.pcSrcE = 1'b0; hz_if.memReadE = 1'b0;
        hz_if.rdE = 5'd0; hz_if.rs1D = 5'd0; hz_if.rs2D = 5'd0;
        set_fwd(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 5'd3);

        // Reset holds the idle pattern despite hazardous inputs.
        cycle("rst_hold", 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4);
        cycle("rst_hold2", 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0);
        set_fwd(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Load-use: one stall cycle then clear.
        cycle("lu_stall", 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9);
        cycle("lu_clear", 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd9);
        check("lu_stallcount", 64'(hz_if.stallCount), 64'd1);
        cycle("lu_rs2", 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 5'd1, 5'd6);
        // x0 destination never stalls.
        cycle("lu_x0", 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        // Redirect beats load-use.
        cycle("pc_over_lu", 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);

        // Forwarding priority.
        set_fwd(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 5'd7);
        cycle("fwd_m", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        set_fwd(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 5'd7);
        cycle("fwd_w", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        set_fwd(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle("fwd_x0", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        set_fwd(1'b1, 1'b1, 5'd2, 5'd9, 5'd9, 5'd2);
        cycle("fwd_split", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        set_fwd(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Memory wait with a redirect arriving mid-wait.
        cycle("miss1", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("miss2_pc", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("miss3", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("pend_ready", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("after_pend", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        // Wait state with ready and redirect together.
        cycle("wait1", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("wait_rdy_pc", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("wait_after", 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            set_fwd($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            cycle("rand", 1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        set_fwd(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle("rand_end", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Reset mid-redirect discards the pending redirect.
        cycle("pend_a", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("pend_b", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("pend_rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("pend_gone", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("pend_gone_flushD", 64'(hz_if.flushD), 64'd0);

        // Timeout: 256 cycles without data.
        for (int i = 0; i < 256; i++) begin
            cycle("tmo_wait", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        end
        cycle("tmo_ready", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle("tmo_ready2", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check("tmo_sticky", 64'(hz_if.imemTimeout), 64'd1);
        cycle("tmo_rst", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("tmo_cleared", 64'(hz_if.imemTimeout), 64'd0);
        check("cnt_cleared", 64'(hz_if.stallCount), 64'd0);
        cycle("tmo_release", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Stall counter wrap: preload just after an edge, then one stall.
        #1;
        dut.stall_count_q = 32'hFFFF_FFFF;
        m_stall = 32'hFFFF_FFFF;
        cycle("wrap_stall", 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0);
        cycle("wrap_after", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("wrap_zero", 64'(hz_if.stallCount), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
